// File: rtl/inv_shift_rows_ser.sv
// Byte-serial AES InvShiftRows: takes one 128-bit state per handshake and emits its 16 bytes
// in InvShiftRows-permuted column-major order. Optional macro ISR_FLUSH_EN adds a synchronous flush input.
module inv_shift_rows_ser #(
  parameter int NCOL = 4,
  parameter int BW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_data,
  output logic          out_last
`ifdef ISR_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  // Handshake: a transfer happens on an edge where valid & ready are both high; valid never
  // depends on ready, and a source holds its data until the transfer completes.

  if (NCOL != 4) begin : g_bad_ncol
    $error("inv_shift_rows_ser: NCOL must be 4");
  end
  if (BW != 8) begin : g_bad_bw
    $error("inv_shift_rows_ser: BW must be 8");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] data_q;
  logic         flush_i;
  logic         beat;
  logic         last_beat;
  logic         accept;
  logic [1:0]   src_col;
  logic [3:0]   src_idx;
  logic [6:0]   src_lsb;

`ifdef ISR_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign beat      = out_valid & out_ready;
  assign last_beat = beat & (cnt == 4'd15);
  assign in_ready  = ~flush_i & ((state == IDLE) | last_beat);
  assign accept    = in_valid & in_ready;
  assign out_last  = out_valid & (cnt == 4'd15);

  // Output byte (col c, row r) comes from source column (c - r) mod 4, same row.
  always_comb begin
    src_col  = cnt[3:2] - cnt[1:0];
    src_idx  = {src_col, cnt[1:0]};
    src_lsb  = {4'd15 - src_idx, 3'b000};
    out_data = data_q[src_lsb +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      data_q    <= 128'd0;
      out_valid <= 1'b0;
    end else if (flush_i) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q    <= in_data;
            cnt       <= 4'd0;
            state     <= SEND;
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (last_beat) begin
            cnt <= 4'd0;
            // A state offered on the final beat chains on without a bubble.
            if (accept) begin
              data_q <= in_data;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end else if (beat) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 4'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
